// File: rtl/poly_pack_buffer_pkg.sv
// Shared types and sizing helpers for the polynomial operand path.
// Used by poly_pack_buffer and by poly_sub users.
package poly_pack_buffer_pkg;

  localparam int unsigned POLY_D = 2;
  localparam int unsigned POLY_N = 2;

  // Index width: clog2(d), but never below one bit so D=2 still has a counter.
  function automatic int unsigned idx_width(input int unsigned d);
    if (d <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(d);
    end
  endfunction

  localparam int unsigned IDX_W = idx_width(POLY_D);

  typedef logic [POLY_N-1:0]        coef_t;
  typedef logic [POLY_D*POLY_N-1:0] poly_t;
  typedef logic [IDX_W-1:0]         idx_t;

endpackage

// File: rtl/poly_pack_buffer_bank.sv
// One D*N coefficient bank: writes a single slice per cycle and can
// clear every slice above the written index to zero-pad a short polynomial.
module poly_bank
  import poly_pack_buffer_pkg::*;
#(
  parameter int unsigned D  = POLY_D,
  parameter int unsigned N  = POLY_N,
  parameter int unsigned IW = idx_width(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] idx,
  input  logic [N-1:0]  coef,
  input  logic          pad_above,
  output logic [D*N-1:0] data
);

  logic [D*N-1:0] data_r;
  logic [D*N-1:0] data_nxt_s;

  // Next bank contents: write slice idx, optionally zero slices above it.
  always_comb begin
    data_nxt_s = data_r;
    for (int k = 0; k < D; k++) begin
      if (wr_en && (idx == IW'(k))) begin
        data_nxt_s[k*N +: N] = coef;
      end else if (wr_en && pad_above && (IW'(k) > idx)) begin
        data_nxt_s[k*N +: N] = {N{1'b0}};
      end else begin
        data_nxt_s[k*N +: N] = data_r[k*N +: N];
      end
    end
  end

  // Bank storage register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r <= {(D*N){1'b0}};
    end else begin
      data_r <= data_nxt_s;
    end
  end

  assign data = data_r;

endmodule

// File: rtl/poly_pack_buffer.sv
// Ping-pong operand buffer: packs a streamed polynomial (one coefficient
// per cycle) into a D*N vector while the other bank is held for the consumer.
module poly_pack_buffer
  import poly_pack_buffer_pkg::*;
#(
  parameter int unsigned D = POLY_D,
  parameter int unsigned N = POLY_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_coef,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D*N-1:0] out_data,
  output logic           len_err
);

  localparam int unsigned   IW       = idx_width(D);
  localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);

  logic [1:0]     bank_full_r;
  logic [1:0]     bank_full_nxt_s;
  logic           wr_bank_r;
  logic           wr_bank_nxt_s;
  logic           rd_bank_r;
  logic           rd_bank_nxt_s;
  logic [IW-1:0]  idx_r;
  logic [IW-1:0]  idx_nxt_s;
  logic           len_err_r;
  logic           len_err_nxt_s;

  logic           accept_s;
  logic           xfer_s;
  logic           at_end_s;
  logic           complete_s;
  logic           short_s;
  logic           len_bad_s;
  logic [1:0]     bank_wr_en_s;
  logic [D*N-1:0] bank_data_s [2];

  assign accept_s   = in_valid & in_ready;
  assign xfer_s     = out_valid & out_ready;
  assign at_end_s   = (idx_r == LAST_IDX);
  assign complete_s = accept_s & (at_end_s | in_last);
  assign short_s    = accept_s & in_last & ~at_end_s;
  // Length is wrong when in_last disagrees with the final index.
  assign len_bad_s  = accept_s & (in_last ^ at_end_s);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_wr_en_s[b] = accept_s & (wr_bank_r == 1'(b));

    poly_bank #(
      .D  (D),
      .N  (N),
      .IW (IW)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (bank_wr_en_s[b]),
      .idx       (idx_r),
      .coef      (in_coef),
      .pad_above (short_s),
      .data      (bank_data_s[b])
    );
  end

  // Next-state for bank selects, full flags, fill index and error flag.
  always_comb begin
    bank_full_nxt_s = bank_full_r;
    wr_bank_nxt_s   = wr_bank_r;
    rd_bank_nxt_s   = rd_bank_r;
    idx_nxt_s       = idx_r;
    len_err_nxt_s   = len_err_r | len_bad_s;
    // Transfer and completion always target different banks, so both apply.
    if (xfer_s) begin
      bank_full_nxt_s[rd_bank_r] = 1'b0;
      rd_bank_nxt_s              = ~rd_bank_r;
    end else begin
      rd_bank_nxt_s = rd_bank_r;
    end
    if (complete_s) begin
      bank_full_nxt_s[wr_bank_r] = 1'b1;
      wr_bank_nxt_s              = ~wr_bank_r;
      idx_nxt_s                  = {IW{1'b0}};
    end else if (accept_s) begin
      idx_nxt_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_full_r <= 2'b00;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      idx_r       <= {IW{1'b0}};
      len_err_r   <= 1'b0;
    end else begin
      bank_full_r <= bank_full_nxt_s;
      wr_bank_r   <= wr_bank_nxt_s;
      rd_bank_r   <= rd_bank_nxt_s;
      idx_r       <= idx_nxt_s;
      len_err_r   <= len_err_nxt_s;
    end
  end

  assign in_ready  = ~bank_full_r[wr_bank_r];
  assign out_valid = bank_full_r[rd_bank_r];
  assign out_data  = bank_data_s[rd_bank_r];
  assign len_err   = len_err_r;

endmodule

// File: tb/tb_poly_pack_buffer.sv
// Directed self-checking bench for poly_pack_buffer (D=4,N=8 and D=2,N=2).
module tb_poly_pack_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_coef;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        len_err;

  logic        in_valid2;
  logic        in_ready2;
  logic [1:0]  in_coef2;
  logic        in_last2;
  logic        out_valid2;
  logic        out_ready2;
  logic [3:0]  out_data2;
  logic        len_err2;

  int n_cmp;
  int n_err;

  poly_pack_buffer #(.D(4), .N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .len_err   (len_err)
  );

  poly_pack_buffer #(.D(2), .N(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_coef   (in_coef2),
    .in_last   (in_last2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2),
    .len_err   (len_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic l);
    in_valid = 1'b1;
    in_coef  = c;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
    n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL reset_len_err got=%0h exp=0", len_err); end
    // out_ready on an empty buffer must be ignored
    drain_one();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL empty_ready got=%0h/%0h exp=0/1", out_valid, in_ready); end
    // reset mid-fill abandons the partial polynomial
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got=%0h exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got=%0h exp=0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL midrst_out_data got=%h exp=00000000", out_data); end
    n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL midrst_len_err got=%0h exp=0", len_err); end
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    send(8'hA4, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL postrst_valid got=%0h exp=1", out_valid); end
    n_cmp++; if (out_data !== 32'hA4A3A2A1) begin n_err++; $display("FAIL postrst_data got=%h exp=a4a3a2a1", out_data); end
    drain_one();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL postrst_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_single();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got=%0h exp=0", out_valid); end
    send(8'h04, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d] got=%0h exp=1", i, out_valid); end
      n_cmp++; if (out_data !== 32'h04030201) begin n_err++; $display("FAIL single_data[%0d] got=%h exp=04030201", i, out_data); end
      step();
    end
    drain_one();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got=%0h exp=0", out_valid); end
    n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL single_len_err got=%0h exp=0", len_err); end
  endtask

  task automatic test_back_pressure();
    for (int k = 0; k < 8; k++) begin
      send(8'(k + 1), (k % 4) == 3);
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%0h exp=0", in_ready); end
    n_cmp++; if (out_data !== 32'h04030201) begin n_err++; $display("FAIL bp_first got=%h exp=04030201", out_data); end
    // third polynomial offered while full: must be ignored entirely
    for (int k = 0; k < 4; k++) begin
      send(8'h99, 1'b1);
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_held_ready got=%0h exp=0", in_ready); end
    n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL bp_len_err got=%0h exp=0", len_err); end
    drain_one();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_rise got=%0h exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_second_valid got=%0h exp=1", out_valid); end
    n_cmp++; if (out_data !== 32'h08070605) begin n_err++; $display("FAIL bp_second got=%h exp=08070605", out_data); end
    drain_one();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%0h exp=0", out_valid); end
    // index was held while full, so a fresh polynomial packs from slice 0
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    send(8'h23, 1'b0);
    send(8'h24, 1'b1);
    n_cmp++; if (out_data !== 32'h24232221) begin n_err++; $display("FAIL bp_idx_held got=%h exp=24232221", out_data); end
    drain_one();
  endtask

  task automatic test_streaming();
    logic [31:0] exp_data;
    exp_data  = 32'h0;
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        in_valid = 1'b1;
        in_coef  = 8'((p + 1) * 16 + k);
        in_last  = (k == 3);
        exp_data[k*8 +: 8] = 8'((p + 1) * 16 + k);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d.%0d] got=%0h exp=1", p, k, in_ready); end
        step();
        n_cmp++; if (out_valid !== (k == 3)) begin n_err++; $display("FAIL stream_valid[%0d.%0d] got=%0h exp=%0h", p, k, out_valid, (k == 3)); end
        if (k == 3) begin
          n_cmp++; if (out_data !== exp_data) begin n_err++; $display("FAIL stream_data[%0d] got=%h exp=%h", p, out_data, exp_data); end
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_end got=%0h exp=0", out_valid); end
    n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL stream_len_err got=%0h exp=0", len_err); end
  endtask

  task automatic test_short();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL short_valid got=%0h exp=1", out_valid); end
    n_cmp++; if (out_data !== 32'h0000BBAA) begin n_err++; $display("FAIL short_data got=%h exp=0000bbaa", out_data); end
    n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL short_len_err got=%0h exp=1", len_err); end
    drain_one();
    for (int p = 0; p < 2; p++) begin
      send(8'h51, 1'b0);
      send(8'h52, 1'b0);
      send(8'h53, 1'b0);
      send(8'h54, 1'b1);
      n_cmp++; if (out_data !== 32'h54535251) begin n_err++; $display("FAIL short_after_data[%0d] got=%h exp=54535251", p, out_data); end
      n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL short_sticky[%0d] got=%0h exp=1", p, len_err); end
      drain_one();
    end
  endtask

  task automatic test_missing_last();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL miss_rst_len_err got=%0h exp=0", len_err); end
    for (int k = 0; k < 4; k++) begin
      send(8'(8'h10 + k), 1'b0);
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL miss_valid got=%0h exp=1", out_valid); end
    n_cmp++; if (out_data !== 32'h13121110) begin n_err++; $display("FAIL miss_data got=%h exp=13121110", out_data); end
    n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL miss_len_err got=%0h exp=1", len_err); end
    drain_one();
  endtask

  task automatic test_small_config();
    in_valid2 = 1'b1; in_coef2 = 2'd3; in_last2 = 1'b0;
    step();
    in_coef2 = 2'd1; in_last2 = 1'b1;
    step();
    in_valid2 = 1'b0; in_last2 = 1'b0;
    n_cmp++; if (out_valid2 !== 1'b1) begin n_err++; $display("FAIL small_valid got=%0h exp=1", out_valid2); end
    n_cmp++; if (out_data2 !== 4'b0111) begin n_err++; $display("FAIL small_data got=%b exp=0111", out_data2); end
    n_cmp++; if (len_err2 !== 1'b0) begin n_err++; $display("FAIL small_len_err got=%0h exp=0", len_err2); end
    out_ready2 = 1'b1;
    step();
    out_ready2 = 1'b0;
    in_valid2 = 1'b1; in_coef2 = 2'd2; in_last2 = 1'b0;
    step();
    step();
    in_valid2 = 1'b0;
    n_cmp++; if (out_data2 !== 4'b1010) begin n_err++; $display("FAIL small_miss_data got=%b exp=1010", out_data2); end
    n_cmp++; if (len_err2 !== 1'b1) begin n_err++; $display("FAIL small_miss_len_err got=%0h exp=1", len_err2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    in_coef    = 8'h00;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    in_valid2  = 1'b0;
    in_coef2   = 2'd0;
    in_last2   = 1'b0;
    out_ready2 = 1'b0;
    test_reset();
    test_single();
    test_back_pressure();
    test_streaming();
    test_short();
    test_missing_last();
    test_small_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
